// File: rtl/rths_job_scheduler.sv
// rths_job_scheduler: round-robin arbiter that shares one sorter between
// NREQ requesters. A winner's key set is pushed into the sorter with a
// one-cycle start pulse. The scheduler then waits for the sorter's ready,
// captures the sorted keys and signals the owner with a one-cycle done.
// Optional feature: define RTHS_SCHED_TIMEOUT_EN to abort a job whose sorter
// never reports ready within TIMEOUT wait cycles (done + err, result zeroed).
module rths_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int NUM     = 4,
  parameter int W       = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*NUM*NUM*W-1:0] req_keys,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           done,
  output logic                      err,
  output logic [NUM*NUM*W-1:0]      res_keys,
  output logic                      busy,
  output logic                      srt_start,
  output logic [NUM*NUM*W-1:0]      srt_keyIn,
  input  logic [NUM*NUM*W-1:0]      srt_keyOut,
  input  logic                      srt_ready
);

  localparam int KW   = NUM * NUM * W;
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_done;
  logic              r_start;
  logic              r_busy;
  logic [KW-1:0]     r_keyin;
  logic [KW-1:0]     r_res;
  logic [IDXW-1:0]   r_rr;
  logic [IDXW-1:0]   r_gidx;
  logic              w_found;
  logic [IDXW-1:0]   w_win;

`ifdef RTHS_SCHED_TIMEOUT_EN
  localparam int CNTW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNTW-1:0]   r_cnt;
  logic              r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign grant     = r_grant;
  assign done      = r_done;
  assign res_keys  = r_res;
  assign busy      = r_busy;
  assign srt_start = r_start;
  assign srt_keyIn = r_keyin;

  // Index base+off folded back into 0..NREQ-1.
  function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDXW'(s);
  endfunction

  // Round-robin pick: first asserted request at or after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req[wrap_idx(r_rr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_idx(r_rr, k);
      end
    end
  end

  // Job sequencing FSM; every output is registered here so reset clears all of them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_keyin <= '0;
      r_res   <= '0;
      r_rr    <= '0;
      r_gidx  <= '0;
`ifdef RTHS_SCHED_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      // Pulses and the sorter input default low; only LOAD entry raises them.
      r_start <= 1'b0;
      r_done  <= '0;
      r_keyin <= '0;
`ifdef RTHS_SCHED_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= NREQ'(1) << w_win;
            r_gidx  <= w_win;
            r_start <= 1'b1;
            r_keyin <= req_keys[w_win*KW +: KW];
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          // Ready may still be high from the previous job here, so it is not looked at.
          r_state <= S_WAIT;
`ifdef RTHS_SCHED_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        S_WAIT: begin
          if (srt_ready) begin
            r_res   <= srt_keyOut;
            r_done  <= r_grant;
            r_state <= S_DONE;
          end
`ifdef RTHS_SCHED_TIMEOUT_EN
          else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
            r_res   <= '0;
            r_done  <= r_grant;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          // The owner moves to lowest priority; no new grant is issued in this cycle.
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_rr    <= (r_gidx == IDXW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rths_job_scheduler.sv
// Directed bench for rths_job_scheduler with a small behavioural sorter model.
module tb_rths_job_scheduler;

  localparam int NREQ = 4;
  localparam int NUM  = 4;
  localparam int W    = 16;
  localparam int KW   = NUM * NUM * W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*KW-1:0] req_keys;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [KW-1:0]     res_keys;
  logic              busy;
  logic              srt_start;
  logic [KW-1:0]     srt_keyIn;

  // Sorter model: ready drops the cycle after start is seen, returns 3 cycles later
  // with exp_sorted on keyOut; 'hold' freezes it to emulate a stuck sorter.
  logic              m_ready  = 1'b1;
  logic [KW-1:0]     m_keyout = '0;
  logic              m_pend   = 1'b0;
  int                m_cnt    = 0;
  logic              hold     = 1'b0;
  logic [KW-1:0]     exp_sorted = '0;
  int                n_start  = 0;

  int n_assert = 0;
  int n_fail   = 0;

  rths_job_scheduler #(.NREQ(NREQ), .NUM(NUM), .W(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_keys(req_keys),
    .grant(grant), .done(done), .err(err), .res_keys(res_keys), .busy(busy),
    .srt_start(srt_start), .srt_keyIn(srt_keyIn), .srt_keyOut(m_keyout),
    .srt_ready(m_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_pend <= srt_start;
    if (m_pend) begin
      m_ready <= 1'b0;
      m_cnt   <= 3;
    end else if (m_cnt != 0 && !hold) begin
      if (m_cnt == 1) begin
        m_ready  <= 1'b1;
        m_keyout <= exp_sorted;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) if (srt_start) n_start++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  function automatic logic [KW-1:0] mk_keys(input int base, input bit asc);
    logic [KW-1:0] v;
    v = '0;
    for (int k = 0; k < NUM*NUM; k++)
      v[k*W +: W] = asc ? W'(base + k) : W'(base + NUM*NUM - 1 - k);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant();
    int i;
    i = 0;
    while (grant == '0 && i < 40) begin step(); i++; end
    chk("grant_seen", KW'(grant != '0), KW'(1));
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (done == '0 && i < 40) begin step(); i++; end
    chk("done_seen", KW'(done != '0), KW'(1));
  endtask

  initial begin
    int st0;
    int cyc;
    int dcount;
    logic [NREQ-1:0] last;

    rst_n = 1'b0; req = '0; req_keys = '0;
    step(); step();
    chk("rst_grant", KW'(grant), KW'(0));
    chk("rst_done", KW'(done), KW'(0));
    chk("rst_busy", KW'(busy), KW'(0));
    chk("rst_start", KW'(srt_start), KW'(0));
    chk("rst_res", res_keys, '0);
    chk("rst_keyin", srt_keyIn, '0);
    rst_n = 1'b1;
    step();

    // Single job from requester 1, keys 15..0
    req_keys[1*KW +: KW] = mk_keys(0, 1'b0);
    exp_sorted = mk_keys(0, 1'b1);
    st0 = n_start;
    req = 4'b0010;
    step();
    chk("s_grant", KW'(grant), KW'(4'b0010));
    chk("s_start", KW'(srt_start), KW'(1));
    chk("s_busy", KW'(busy), KW'(1));
    chk("s_keyin", srt_keyIn, mk_keys(0, 1'b0));
    step();
    chk("s_start_off", KW'(srt_start), KW'(0));
    chk("s_keyin_off", srt_keyIn, '0);
    wait_done();
    chk("s_done", KW'(done), KW'(4'b0010));
    chk("s_err", KW'(err), KW'(0));
    chk("s_res", res_keys, mk_keys(0, 1'b1));
    chk("s_grant_done", KW'(grant), KW'(4'b0010));
    req = '0;
    step();
    chk("s_done_off", KW'(done), KW'(0));
    chk("s_busy_off", KW'(busy), KW'(0));
    chk("s_grant_off", KW'(grant), KW'(0));
    chk("s_one_start", KW'(n_start - st0), KW'(1));

    // Asynchronous reset while waiting on the sorter
    req_keys[0 +: KW] = mk_keys(16, 1'b0);
    hold = 1'b1;
    req = 4'b0001;
    wait_grant();
    step(); step();
    chk("r_busy_pre", KW'(busy), KW'(1));
    rst_n = 1'b0;
    #1;
    chk("r_grant", KW'(grant), KW'(0));
    chk("r_done", KW'(done), KW'(0));
    chk("r_err", KW'(err), KW'(0));
    chk("r_busy", KW'(busy), KW'(0));
    chk("r_start", KW'(srt_start), KW'(0));
    chk("r_res", res_keys, '0);
    req = '0;
    hold = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("r_idle_busy", KW'(busy), KW'(0));
    chk("r_idle_grant", KW'(grant), KW'(0));

    // Round-robin with all four requesting
    for (int r = 0; r < NREQ; r++) req_keys[r*KW +: KW] = mk_keys(64 * (r + 1), 1'b0);
    req = 4'b1111;
    for (int j = 0; j < NREQ; j++) begin
      wait_grant();
      chk("rr_grant", KW'(grant), KW'(4'b0001 << j));
      exp_sorted = mk_keys(64 * (j + 1), 1'b1);
      wait_done();
      chk("rr_done", KW'(done), KW'(4'b0001 << j));
      chk("rr_res", res_keys, mk_keys(64 * (j + 1), 1'b1));
      req[j] = 1'b0;
      step();
      chk("rr_no_grant_after_done", KW'(grant), KW'(0));
    end
    step();

    // Fairness: requester 0 stays high after its done while requester 2 is waiting
    req = 4'b0001;
    wait_grant();
    chk("f_grant0", KW'(grant), KW'(4'b0001));
    wait_done();
    req = 4'b0101;
    step();
    wait_grant();
    chk("f_grant2", KW'(grant), KW'(4'b0100));
    wait_done();
    chk("f_done2", KW'(done), KW'(4'b0100));
    req = 4'b0001;
    step();
    wait_grant();
    chk("f_grant0_again", KW'(grant), KW'(4'b0001));
    wait_done();
    req = '0;
    step();

    // Abandon: requester 1 drops its request while the job is in flight
    st0 = n_start;
    req = 4'b0010;
    wait_grant();
    chk("a_grant", KW'(grant), KW'(4'b0010));
    step(); step(); step();
    req = '0;
    dcount = 0;
    last = '0;
    for (int i = 0; i < 20; i++) begin
      if (done != '0) begin dcount++; last = done; end
      step();
    end
    chk("a_done_count", KW'(dcount), KW'(1));
    chk("a_done_who", KW'(last), KW'(4'b0010));
    chk("a_one_start", KW'(n_start - st0), KW'(1));
    chk("a_busy", KW'(busy), KW'(0));

    // Stuck sorter on requester 2
    hold = 1'b1;
    req = 4'b0100;
    wait_grant();
    chk("t_grant", KW'(grant), KW'(4'b0100));
    cyc = 0;
    while (done == '0 && cyc < 30) begin step(); cyc++; end
`ifdef RTHS_SCHED_TIMEOUT_EN
    chk("t_cycles", KW'(cyc), KW'(10));
    chk("t_done", KW'(done), KW'(4'b0100));
    chk("t_err", KW'(err), KW'(1));
    chk("t_res", res_keys, '0);
    req = '0;
    step();
    chk("t_err_off", KW'(err), KW'(0));
    chk("t_busy_off", KW'(busy), KW'(0));
    hold = 1'b0;
`else
    chk("t_no_done", KW'(cyc), KW'(30));
    chk("t_busy_held", KW'(busy), KW'(1));
    exp_sorted = mk_keys(500, 1'b1);
    hold = 1'b0;
    wait_done();
    chk("t_late_done", KW'(done), KW'(4'b0100));
    chk("t_late_err", KW'(err), KW'(0));
    chk("t_late_res", res_keys, mk_keys(500, 1'b1));
    req = '0;
    step();
    chk("t_busy_off", KW'(busy), KW'(0));
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
